// File: rtl/aes_reg_pkg.sv
// Shared types for the AES byte-register slice: byte width, byte type and register states.
package aes_reg_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } reg_state_t;

endpackage

// File: rtl/mod_reg4_4to1.sv
// Parallel-in, serial-out byte register: loads N bytes at once and streams them out one per rd_en.
// Define REG4_MSB_FIRST_EN to emit i[N-1] first instead of i[0].
module mod_reg4_4to1
    import aes_reg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [N-1:0][BYTE_W-1:0]     i,
    output logic [BYTE_W-1:0]            o,
    output logic                         o_valid,
    output logic                         last,
    output logic                         reg_empty,
    output logic                         wr_err
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    reg_state_t                  state;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               idx;
    logic [N-1:0][BYTE_W-1:0]    data_buf;
    logic                        at_last;
    logic                        accept;

    assign at_last   = (state == SHIFT) && (cnt == LAST_IDX);
    assign accept    = wr_en && ((state == IDLE) || (rd_en && at_last));
    assign last      = at_last;
    assign o_valid   = (state == SHIFT);
    assign reg_empty = (state == IDLE);

`ifdef REG4_MSB_FIRST_EN
    assign idx = LAST_IDX - cnt;
`else
    assign idx = cnt;
`endif

    always_comb begin
        o = '0;
        if (state == SHIFT) begin
            o = data_buf[idx];
        end
    end

    // A rejected load only raises wr_err; a read issued in the same cycle still advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf <= '0;
            cnt      <= '0;
            state    <= IDLE;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= wr_en && !accept;
            if (accept) begin
                data_buf <= i;
                cnt      <= '0;
                state    <= SHIFT;
            end else if (state == SHIFT && rd_en) begin
                if (at_last) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_reg4_4to1.sv
// Self-checking bench for mod_reg4_4to1 against a byte-queue reference model.
// Define REG4_MSB_FIRST_EN for both bench and RTL to check the MSB-first build.
module tb_mod_reg4_4to1;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [N-1:0][7:0] i = '0;
    logic [7:0]        o;
    logic              o_valid;
    logic              last;
    logic              reg_empty;
    logic              wr_err;

    int errors = 0;
    int checks = 0;

    // Reference: the bytes still to be emitted, front first, plus the pending error pulse.
    logic [7:0] model_q[$];
    logic       model_err = 1'b0;

    mod_reg4_4to1 #(.N(N)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .i(i),
        .o(o),
        .o_valid(o_valid),
        .last(last),
        .reg_empty(reg_empty),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_vec();
        logic [7:0] ob;
        ob = (model_q.size() > 0) ? model_q[0] : 8'h00;
        return {ob, 1'(model_q.size() > 0), 1'(model_q.size() == 1),
                1'(model_q.size() == 0), model_err};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {o, o_valid, last, reg_empty, wr_err};
    endfunction

    task automatic model_clear();
        model_q.delete();
        model_err = 1'b0;
    endtask

    // Drive one cycle, advance the model at the edge, leave time at edge+1.
    task automatic step(input logic w, input logic r, input logic [N-1:0][7:0] word);
        logic acc;
        wr_en = w;
        rd_en = r;
        i     = word;
        @(posedge clk);
        acc = w && (model_q.size() == 0 || (r && model_q.size() == 1));
        model_err = w && !acc;
        if (r && model_q.size() > 0) void'(model_q.pop_front());
        if (acc) begin
            model_q.delete();
`ifdef REG4_MSB_FIRST_EN
            for (int k = N - 1; k >= 0; k--) model_q.push_back(word[k]);
`else
            for (int k = 0; k < N; k++) model_q.push_back(word[k]);
`endif
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== exp_vec() || dut_vec() !== 12'h002) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h expected %h", dut_vec(), 12'h002);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, '0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_serialise();
        step(1'b1, 1'b0, {8'h03, 8'h02, 8'h01, 8'h00});
        for (int k = 0; k <= N; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL serialise[%0d]: got %h expected %h", k, dut_vec(), exp_vec());
            end
            if (k < N) step(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_reject();
        step(1'b1, 1'b0, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
        step(1'b1, 1'b0, {8'hB3, 8'hB2, 8'hB1, 8'hB0});
        checks++;
        if (dut_vec() !== exp_vec() || wr_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reject_pulse: got %h expected %h", dut_vec(), exp_vec());
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (dut_vec() !== exp_vec() || wr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reject_clear: got %h expected %h", dut_vec(), exp_vec());
        end
        repeat (N) step(1'b0, 1'b1, '0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, {8'h13, 8'h12, 8'h11, 8'h10});
        repeat (N - 1) step(1'b0, 1'b1, '0);
        checks++;
        if (dut_vec() !== exp_vec() || last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_last: got %h expected %h", dut_vec(), exp_vec());
        end
        step(1'b1, 1'b1, {8'h23, 8'h22, 8'h21, 8'h20});
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut_vec() !== exp_vec() || o_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_word[%0d]: got %h expected %h", k, dut_vec(), exp_vec());
            end
            step(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, {8'h44, 8'h43, 8'h42, 8'h41});
        repeat (5) begin
            step(1'b0, 1'b0, '0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL stall_hold: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        repeat (N) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL idle_read: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, {8'h58, 8'h57, 8'h56, 8'h55});
        repeat (2) step(1'b0, 1'b1, '0);
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b1, '0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL after_reset: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [N-1:0][7:0] word;
        logic w, r;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < N; k++) word[k] = 8'($urandom);
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
            step(w, r, word);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", n, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        $display("[TB] starting mod_reg4_4to1 bench");
        test_reset();
        test_serialise();
        test_reject();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
